// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse cipher: FSM state encodings,
// Rcon table, forward S-box, key-schedule steps and InvShiftRows.
package aes_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_KEYEXP = 3'd1;
    localparam logic [2:0] ST_ROUND  = 3'd2;
    localparam logic [2:0] ST_FINAL  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits [8*(255-b) +: 8]; ~b gives 255-b directly.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // SubWord(RotWord(w)) with the round constant folded into the top byte.
    function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // K_r from K_{r+1}; rc is Rcon[r+1].
    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]   ^ k[63:32];
        w2 = k[63:32]  ^ k[95:64];
        w1 = k[95:64]  ^ k[127:96];
        w0 = k[127:96] ^ key_core(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    // K_{r+1} from K_r; rc is Rcon[r+1].
    function automatic logic [127:0] forward_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ key_core(k[31:0], rc);
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Row r of the column-major state rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: 256-entry combinational lookup, one byte in, one out.
module aes_inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Table lookup; entry 0 is the top byte.
    always_comb begin
        dout = INV_SBOX_TBL[{~din, 3'b000} +: 8];
    end

endmodule

// File: rtl/mixColumnsDecrypt.sv
// InvMixColumns over a full 128-bit column-major state.
module mixColumnsDecrypt (
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ {3'b000, b[7], b[7], 1'b0, b[7], b[7]};
    endfunction

    // GF(2^8) multiply by a constant whose bits select b, 2b, 4b, 8b.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^
               (m[1] ? x2 : 8'h00) ^ (m[0] ? b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // Four independent column transforms.
    always_comb begin
        data_out = '0;
        for (int c = 0; c < 4; c++) begin
            data_out[127 - 32*c -: 32] = inv_mix_col(data_in[127 - 32*c -: 32]);
        end
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys
// regenerated backwards on the fly.
// Optional macro AES_KEY_EXPAND_EN: key input is the cipher key K0 and
// K10 is derived in a KEYEXP phase before decryption starts.
//
// state  | meaning
// IDLE   | waiting for a block, in_ready high
// KEYEXP | forward key expansion K0 -> K10 (macro build only)
// ROUND  | inverse rounds 9..1, full round with InvMixColumns
// FINAL  | last round without InvMixColumns, registers the plaintext
// DONE   | out_valid high, waiting for out_ready
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);

    logic [2:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
`ifdef AES_KEY_EXPAND_EN
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_fwd;
`endif

    logic [7:0]   rcon_inv;
    logic [127:0] key_inv;
    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] mixed;

    // Round constant for stepping the key back one round; FINAL recovers K0.
    always_comb begin
        rcon_inv = (state_q == ST_FINAL) ? 8'h01 : rcon(round_q + 4'd1);
        key_inv  = inv_step(key_q, rcon_inv);
        sr       = inv_shift_rows(blk_q);
        ark      = sb ^ key_inv;
    end

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (
            .din  (sr[127 - 8*g -: 8]),
            .dout (sb[127 - 8*g -: 8])
        );
    end

    mixColumnsDecrypt u_mix (
        .data_in  (ark),
        .data_out (mixed)
    );

`ifdef AES_KEY_EXPAND_EN
    // Forward schedule step used while walking K0 up to K10.
    always_comb begin
        key_fwd = forward_step(key_q, rcon(round_q));
    end
`endif

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    // Next-state and datapath selection for the round FSM.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        blk_d       = blk_q;
        key_d       = key_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef AES_KEY_EXPAND_EN
        ct_d        = ct_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    key_d   = key;
`ifdef AES_KEY_EXPAND_EN
                    ct_d    = in;
                    round_d = 4'd1;
                    state_d = ST_KEYEXP;
`else
                    blk_d   = in ^ key;
                    round_d = 4'd9;
                    state_d = ST_ROUND;
`endif
                end
            end
`ifdef AES_KEY_EXPAND_EN
            ST_KEYEXP: begin
                key_d   = key_fwd;
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    blk_d   = ct_q ^ key_fwd;
                    round_d = 4'd9;
                    state_d = ST_ROUND;
                end
            end
`endif
            ST_ROUND: begin
                blk_d = mixed;
                key_d = key_inv;
                if (round_q == 4'd1) begin
                    state_d = ST_FINAL;
                end else begin
                    round_d = round_q - 4'd1;
                end
            end
            ST_FINAL: begin
                out_d       = ark;
                out_valid_d = 1'b1;
                key_d       = key_inv;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that clears every partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            blk_q       <= '0;
            key_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_KEY_EXPAND_EN
            ct_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef AES_KEY_EXPAND_EN
            ct_q        <= ct_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core with a scoreboard queue of expected
// plaintexts. Honours AES_KEY_EXPAND_EN (K0 keys, longer latency).
module tb_aes_decrypt_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_blk = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_blk;

    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_KEY_EXPAND_EN
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int LAT    = 21;
    localparam int PERIOD = 22;
`else
    localparam logic [127:0] KEY_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam int LAT    = 11;
    localparam int PERIOD = 12;
`endif

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q[$];

    aes_decrypt_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_blk),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_blk)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic chk_out(input string tag);
        if (exp_q.size() == 0) begin
            expire({tag, "_unexpected_output"});
        end else begin
            chk(tag, out_blk, exp_q.pop_front());
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] k,
                             input logic [127:0] pt, input int hold, input bit busy);
        int cyc;
        in_valid = 1'b1;
        in_blk   = ct;
        key      = k;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        exp_q.push_back(pt);
        tick();
        in_valid = 1'b0;
        in_blk   = ~ct;
        key      = ~k;
        cyc = 1;
        while (!out_valid && cyc < LAT + 20) begin
            if (busy && cyc == 3) begin
                in_valid = 1'b1;
                in_blk   = CT_B;
                key      = KEY_B;
                chk({tag, "_busy_in_ready"}, in_ready, 1'b0);
            end
            if (busy && cyc == 5) in_valid = 1'b0;
            tick();
            cyc++;
        end
        if (!out_valid) begin
            expire({tag, "_out_valid"});
        end else begin
            chk({tag, "_latency"}, cyc, LAT);
        end
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_out"}, out_blk, pt);
            tick();
        end
        out_ready = 1'b1;
        chk({tag, "_valid_at_accept"}, out_valid, 1'b1);
        chk_out({tag, "_out"});
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, in_ready, 1'b1);
        chk({tag, "_idle_out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        int n_in;
        int n_out;
        int t;
        int hs[2];

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out", out_blk, '0);
        chk("reset_in_ready_in_rst", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready_after", in_ready, 1'b1);

        run_block("c1", CT_C1, KEY_C1, PT_C1, 0, 1'b0);
        run_block("fips_b", CT_B, KEY_B, PT_B, 5, 1'b0);
        run_block("busy", CT_C1, KEY_C1, PT_C1, 0, 1'b1);

        // Abort in cycle 5 after the handshake.
        in_valid = 1'b1;
        in_blk   = CT_B;
        key      = KEY_B;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready_low", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out", out_blk, '0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        repeat (PERIOD + 2) tick();
        chk("mid_rst_no_late_output", out_valid, 1'b0);
        run_block("after_rst", CT_C1, KEY_C1, PT_C1, 0, 1'b0);

        // Back-to-back with out_ready tied high and in_valid held.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_blk    = CT_C1;
        key       = KEY_C1;
        n_in  = 0;
        n_out = 0;
        t     = 0;
        hs[0] = 0;
        hs[1] = 0;
        while (n_out < 2 && t < 4 * PERIOD) begin
            if (in_valid && in_ready && n_in < 2) begin
                hs[n_in] = t;
                exp_q.push_back((n_in == 0) ? PT_C1 : PT_B);
                n_in++;
            end
            if (out_valid && out_ready) begin
                chk_out("b2b_out");
                n_out++;
            end
            tick();
            t++;
            if (n_in == 1) begin
                in_blk = CT_B;
                key    = KEY_B;
            end else if (n_in >= 2) begin
                in_valid = 1'b0;
            end
        end
        if (n_out < 2) begin
            expire("b2b_outputs");
        end else begin
            chk("b2b_spacing", hs[1] - hs[0], PERIOD);
        end
        out_ready = 1'b0;
        chk("b2b_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
